// File: rtl/lte_ul_ctrl_pkg.sv
// Shared types and constants for the uplink antenna-map controller.
// The map holds 8 fields of 4 bits each: a 3-bit position and a reserved bit.
`timescale 1ns/1ps
package lte_ul_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      PEND  = 2'd2
   } cfg_state_e;

   localparam int ANT_NUM = 8;
   localparam int POS_W   = 3;
   localparam int FIELD_W = 4;
   localparam int IDX_W   = 3;
   localparam int MAP_W   = ANT_NUM * FIELD_W;

   localparam logic [MAP_W-1:0] IDENT_MAP = 32'h7654_3210;

   function automatic logic [FIELD_W-1:0] get_field(input logic [MAP_W-1:0] map,
                                                    input logic [IDX_W-1:0] idx);
      return map[idx*FIELD_W +: FIELD_W];
   endfunction

endpackage

// File: rtl/lte_ul_hd_watchdog.sv
// Frame-header watchdog: measures the header-to-header distance and sorts each
// header into good or early. It also raises a lost flag and counts good frames.
`timescale 1ns/1ps
module lte_ul_hd_watchdog #(
   parameter logic [23:0] FRAME_MAX = 24'd2457599,
   parameter int unsigned HD_TOL    = 8
) (
   input  logic        clk,
   input  logic        asy_rst_n,
   input  logic        i_fram_hd,
   output logic        hd_good,
   output logic        o_hd_early,
   output logic        o_hd_lost,
   output logic [15:0] o_frame_num
);

   localparam logic [23:0] WIN_LO  = FRAME_MAX - 24'(HD_TOL);
   localparam logic [23:0] WIN_HI  = FRAME_MAX + 24'(HD_TOL);
   localparam logic [23:0] CNT_SAT = 24'hFF_FFFF;

   logic [23:0] cnt_q, cnt_d;
   logic        first_hd_q, first_hd_d;
   logic        early_q, early_d;
   logic        lost_q, lost_d;
   logic [15:0] frame_q, frame_d;
   logic        in_window;
   logic        hd_early;

   assign in_window = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
   assign hd_good   = i_fram_hd && (first_hd_q || in_window || lost_q);
   assign hd_early  = i_fram_hd && !first_hd_q && !lost_q && (cnt_q < WIN_LO);

   // Lost rises on the edge where the counter steps past the window, so any
   // header seen beyond the window always finds the lost flag already set.
   always_comb begin
      cnt_d      = cnt_q;
      first_hd_d = first_hd_q;
      early_d    = hd_early;
      lost_d     = lost_q;
      frame_d    = frame_q;

      if (i_fram_hd) begin
         cnt_d  = 24'd0;
         lost_d = 1'b0;
      end else begin
         if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 24'd1;
         end
         if (cnt_q >= WIN_HI) begin
            lost_d = 1'b1;
         end
      end

      if (hd_good) begin
         frame_d    = frame_q + 16'd1;
         first_hd_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge asy_rst_n) begin
      if (!asy_rst_n) begin
         cnt_q      <= 24'd0;
         first_hd_q <= 1'b1;
         early_q    <= 1'b0;
         lost_q     <= 1'b0;
         frame_q    <= 16'd0;
      end else begin
         cnt_q      <= cnt_d;
         first_hd_q <= first_hd_d;
         early_q    <= early_d;
         lost_q     <= lost_d;
         frame_q    <= frame_d;
      end
   end

   assign o_hd_early  = early_q;
   assign o_hd_lost   = lost_q;
   assign o_frame_num = frame_q;

endmodule

// File: rtl/lte_ul_antmap_ctrl.sv
// Antenna position map controller: validates a new map over 8 cycles, parks it in
// a shadow register and commits it only on a good frame header.
`timescale 1ns/1ps
module lte_ul_antmap_ctrl
   import lte_ul_ctrl_pkg::*;
#(
   parameter logic [23:0]      FRAME_MAX = 24'd2457599,
   parameter int unsigned      HD_TOL    = 8,
   parameter logic [MAP_W-1:0] IDENT_MAP = lte_ul_ctrl_pkg::IDENT_MAP
) (
   input  logic             clk,
   input  logic             asy_rst_n,
   input  logic [MAP_W-1:0] i_cfg_map,
   input  logic             i_cfg_wr,
   input  logic             i_fram_hd,
   output logic [MAP_W-1:0] o_ant_posinfo,
   output logic             o_cfg_busy,
   output logic             o_cfg_done,
   output logic             o_cfg_err,
   output logic             o_hd_early,
   output logic             o_hd_lost,
   output logic [15:0]      o_frame_num
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ANT_NUM - 1);

   cfg_state_e             state_q, state_d;
   logic [MAP_W-1:0]       shadow_q, shadow_d;
   logic [MAP_W-1:0]       posinfo_q, posinfo_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [ANT_NUM-1:0]     bitmap_q, bitmap_d;
   logic                   chk_err_q, chk_err_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   cfg_err_q, cfg_err_d;
   logic                   hd_good;
   logic [FIELD_W-1:0]     cur_field;
   logic                   field_bad;

   lte_ul_hd_watchdog #(
      .FRAME_MAX (FRAME_MAX),
      .HD_TOL    (HD_TOL)
   ) u_hd_watchdog (
      .clk         (clk),
      .asy_rst_n   (asy_rst_n),
      .i_fram_hd   (i_fram_hd),
      .hd_good     (hd_good),
      .o_hd_early  (o_hd_early),
      .o_hd_lost   (o_hd_lost),
      .o_frame_num (o_frame_num)
   );

   assign cur_field = get_field(shadow_q, idx_q);
   assign field_bad = cur_field[FIELD_W-1] || bitmap_q[cur_field[POS_W-1:0]];

   // A header arriving in CHECK is ignored here; only PEND may commit.
   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      posinfo_d = posinfo_q;
      idx_d     = idx_q;
      bitmap_d  = bitmap_q;
      chk_err_d = chk_err_q;
      cfg_err_d = cfg_err_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_cfg_wr) begin
               shadow_d  = i_cfg_map;
               cfg_err_d = 1'b0;
               bitmap_d  = '0;
               chk_err_d = 1'b0;
               idx_d     = '0;
               state_d   = CHECK;
            end
         end
         CHECK: begin
            if (!field_bad) begin
               bitmap_d[cur_field[POS_W-1:0]] = 1'b1;
            end
            chk_err_d = chk_err_q || field_bad;
            idx_d     = idx_q + 3'd1;
            if (idx_q == LAST_IDX) begin
               if (chk_err_q || field_bad) begin
                  cfg_err_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            if (hd_good) begin
               posinfo_d = shadow_q;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q != IDLE) && i_cfg_wr) begin
         cfg_err_d = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge asy_rst_n) begin
      if (!asy_rst_n) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         posinfo_q <= IDENT_MAP;
         idx_q     <= '0;
         bitmap_q  <= '0;
         chk_err_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         posinfo_q <= posinfo_d;
         idx_q     <= idx_d;
         bitmap_q  <= bitmap_d;
         chk_err_q <= chk_err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign o_ant_posinfo = posinfo_q;
   assign o_cfg_busy    = busy_q;
   assign o_cfg_done    = done_q;
   assign o_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_lte_ul_antmap_ctrl.sv
// Directed bench for the antenna-map controller with a short 100-cycle frame.
// Expected values are hand-derived and tracked in exp_map / exp_frame.
`timescale 1ns/1ps
module tb_lte_ul_antmap_ctrl;

   logic        clk = 1'b0;
   logic        asy_rst_n = 1'b1;
   logic [31:0] i_cfg_map = 32'h0;
   logic        i_cfg_wr = 1'b0;
   logic        i_fram_hd = 1'b0;
   logic [31:0] o_ant_posinfo;
   logic        o_cfg_busy;
   logic        o_cfg_done;
   logic        o_cfg_err;
   logic        o_hd_early;
   logic        o_hd_lost;
   logic [15:0] o_frame_num;

   int          n_tests = 0;
   int          n_fail = 0;
   int          since_hd = 0;
   logic [31:0] exp_map;
   logic [15:0] exp_frame;

   lte_ul_antmap_ctrl #(
      .FRAME_MAX (24'd99),
      .HD_TOL    (2),
      .IDENT_MAP (32'h7654_3210)
   ) dut (
      .clk           (clk),
      .asy_rst_n     (asy_rst_n),
      .i_cfg_map     (i_cfg_map),
      .i_cfg_wr      (i_cfg_wr),
      .i_fram_hd     (i_fram_hd),
      .o_ant_posinfo (o_ant_posinfo),
      .o_cfg_busy    (o_cfg_busy),
      .o_cfg_done    (o_cfg_done),
      .o_cfg_err     (o_cfg_err),
      .o_hd_early    (o_hd_early),
      .o_hd_lost     (o_hd_lost),
      .o_frame_num   (o_frame_num)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "[TB] timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
      since_hd++;
   endtask

   // Header edge lands so that the counter samples gap-1 at that edge.
   task automatic send_hd(input int gap);
      while (since_hd < gap - 1) step();
      i_fram_hd = 1'b1;
      step();
      i_fram_hd = 1'b0;
      since_hd = 0;
   endtask

   task automatic write_map(input logic [31:0] m);
      i_cfg_map = m;
      i_cfg_wr  = 1'b1;
      step();
      i_cfg_wr  = 1'b0;
   endtask

   task automatic test_reset();
      #2 asy_rst_n = 1'b0;
      #5;
      exp_map   = 32'h7654_3210;
      exp_frame = 16'd0;
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL rst_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", o_cfg_busy); end
      n_tests++; if (o_cfg_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b want 0", o_cfg_done); end
      n_tests++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_err: got %b want 0", o_cfg_err); end
      n_tests++; if (o_hd_early !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_early: got %b want 0", o_hd_early); end
      n_tests++; if (o_hd_lost !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_lost: got %b want 0", o_hd_lost); end
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL rst_frame: got %0d want %0d", o_frame_num, exp_frame); end
      @(negedge clk);
      asy_rst_n = 1'b1;
      since_hd = 0;
      step();
   endtask

   task automatic test_frame_headers();
      send_hd(5);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) send_hd(100);
         exp_frame = exp_frame + 16'd1;
         n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL hdr_frame%0d: got %0d want %0d", i, o_frame_num, exp_frame); end
         n_tests++; if (o_hd_early !== 1'b0) begin n_fail++; $display("[TB] FAIL hdr_early%0d: got %b want 0", i, o_hd_early); end
         n_tests++; if (o_hd_lost !== 1'b0) begin n_fail++; $display("[TB] FAIL hdr_lost%0d: got %b want 0", i, o_hd_lost); end
         n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL hdr_map%0d: got %h want %h", i, o_ant_posinfo, exp_map); end
      end
   endtask

   task automatic test_commit();
      repeat (10) step();
      write_map(32'h0123_4567);
      n_tests++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL commit_err: got %b want 0", o_cfg_err); end
      for (int i = 0; i < 9; i++) begin
         n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL commit_busy%0d: got %b want 1", i, o_cfg_busy); end
         if (i < 8) step();
      end
      while (since_hd < 98) step();
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL commit_early_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_done !== 1'b0) begin n_fail++; $display("[TB] FAIL commit_done_pre: got %b want 0", o_cfg_done); end
      send_hd(100);
      exp_map   = 32'h0123_4567;
      exp_frame = exp_frame + 16'd1;
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL commit_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_done !== 1'b1) begin n_fail++; $display("[TB] FAIL commit_done: got %b want 1", o_cfg_done); end
      n_tests++; if (o_cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL commit_busy_post: got %b want 0", o_cfg_busy); end
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL commit_frame: got %0d want %0d", o_frame_num, exp_frame); end
      step();
      n_tests++; if (o_cfg_done !== 1'b0) begin n_fail++; $display("[TB] FAIL commit_done_pulse: got %b want 0", o_cfg_done); end
   endtask

   task automatic test_reject();
      logic [31:0] bad_maps [2];
      bad_maps[0] = 32'h0123_4566;
      bad_maps[1] = 32'h0000_0008;
      for (int k = 0; k < 2; k++) begin
         write_map(bad_maps[k]);
         n_tests++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rej%0d_err_clr: got %b want 0", k, o_cfg_err); end
         repeat (7) step();
         n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rej%0d_busy: got %b want 1", k, o_cfg_busy); end
         step();
         n_tests++; if (o_cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rej%0d_idle: got %b want 0", k, o_cfg_busy); end
         n_tests++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL rej%0d_err: got %b want 1", k, o_cfg_err); end
         n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL rej%0d_map: got %h want %h", k, o_ant_posinfo, exp_map); end
      end
      send_hd(100);
      exp_frame = exp_frame + 16'd1;
      n_tests++; if (o_cfg_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rej_hd_done: got %b want 0", o_cfg_done); end
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL rej_hd_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL rej_hd_frame: got %0d want %0d", o_frame_num, exp_frame); end
   endtask

   task automatic test_back_to_back();
      repeat (3) step();
      write_map(32'h1076_5432);
      repeat (8) step();
      n_tests++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_err_pre: got %b want 0", o_cfg_err); end
      write_map(32'h7654_3210);
      n_tests++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_err: got %b want 1", o_cfg_err); end
      n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy: got %b want 1", o_cfg_busy); end
      repeat (2) step();
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL b2b_map_hold: got %h want %h", o_ant_posinfo, exp_map); end
      send_hd(100);
      exp_map   = 32'h1076_5432;
      exp_frame = exp_frame + 16'd1;
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL b2b_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done: got %b want 1", o_cfg_done); end
      n_tests++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_err_sticky: got %b want 1", o_cfg_err); end
   endtask

   task automatic test_early();
      repeat (2) step();
      write_map(32'h3210_7654);
      n_tests++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL early_err_clr: got %b want 0", o_cfg_err); end
      repeat (8) step();
      for (int k = 0; k < 2; k++) begin
         send_hd(50);
         n_tests++; if (o_hd_early !== 1'b1) begin n_fail++; $display("[TB] FAIL early%0d_pulse: got %b want 1", k, o_hd_early); end
         n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL early%0d_map: got %h want %h", k, o_ant_posinfo, exp_map); end
         n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL early%0d_frame: got %0d want %0d", k, o_frame_num, exp_frame); end
         n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL early%0d_busy: got %b want 1", k, o_cfg_busy); end
         step();
         n_tests++; if (o_hd_early !== 1'b0) begin n_fail++; $display("[TB] FAIL early%0d_pulse_end: got %b want 0", k, o_hd_early); end
      end
      send_hd(100);
      exp_map   = 32'h3210_7654;
      exp_frame = exp_frame + 16'd1;
      n_tests++; if (o_hd_early !== 1'b0) begin n_fail++; $display("[TB] FAIL early_good_pulse: got %b want 0", o_hd_early); end
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL early_good_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL early_good_frame: got %0d want %0d", o_frame_num, exp_frame); end
      n_tests++; if (o_cfg_done !== 1'b1) begin n_fail++; $display("[TB] FAIL early_good_done: got %b want 1", o_cfg_done); end
   endtask

   task automatic test_lost();
      repeat (2) step();
      write_map(32'h5432_1076);
      repeat (8) step();
      while (since_hd < 101) step();
      n_tests++; if (o_hd_lost !== 1'b0) begin n_fail++; $display("[TB] FAIL lost_pre: got %b want 0", o_hd_lost); end
      step();
      n_tests++; if (o_hd_lost !== 1'b1) begin n_fail++; $display("[TB] FAIL lost_rise: got %b want 1", o_hd_lost); end
      repeat (5) step();
      n_tests++; if (o_hd_lost !== 1'b1) begin n_fail++; $display("[TB] FAIL lost_hold: got %b want 1", o_hd_lost); end
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL lost_map_hold: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL lost_busy: got %b want 1", o_cfg_busy); end
      send_hd(0);
      exp_map   = 32'h5432_1076;
      exp_frame = exp_frame + 16'd1;
      n_tests++; if (o_hd_lost !== 1'b0) begin n_fail++; $display("[TB] FAIL lost_fall: got %b want 0", o_hd_lost); end
      n_tests++; if (o_hd_early !== 1'b0) begin n_fail++; $display("[TB] FAIL lost_early: got %b want 0", o_hd_early); end
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL lost_frame: got %0d want %0d", o_frame_num, exp_frame); end
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL lost_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_done !== 1'b1) begin n_fail++; $display("[TB] FAIL lost_done: got %b want 1", o_cfg_done); end
   endtask

   task automatic test_hd_during_check();
      while (since_hd < 94) step();
      write_map(32'h0123_4567);
      send_hd(100);
      exp_frame = exp_frame + 16'd1;
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL chk_hd_frame: got %0d want %0d", o_frame_num, exp_frame); end
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL chk_hd_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_done !== 1'b0) begin n_fail++; $display("[TB] FAIL chk_hd_done: got %b want 0", o_cfg_done); end
      n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL chk_hd_busy: got %b want 1", o_cfg_busy); end
      send_hd(100);
      exp_map   = 32'h0123_4567;
      exp_frame = exp_frame + 16'd1;
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL chk_next_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_done !== 1'b1) begin n_fail++; $display("[TB] FAIL chk_next_done: got %b want 1", o_cfg_done); end
   endtask

   task automatic test_reset_in_pend();
      repeat (2) step();
      write_map(32'h1076_5432);
      repeat (8) step();
      n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rstp_busy_pre: got %b want 1", o_cfg_busy); end
      @(negedge clk);
      asy_rst_n = 1'b0;
      #1;
      exp_map   = 32'h7654_3210;
      exp_frame = 16'd0;
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL rstp_map: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstp_busy: got %b want 0", o_cfg_busy); end
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL rstp_frame: got %0d want %0d", o_frame_num, exp_frame); end
      @(negedge clk);
      asy_rst_n = 1'b1;
      since_hd = 0;
      send_hd(5);
      exp_frame = 16'd1;
      n_tests++; if (o_ant_posinfo !== exp_map) begin n_fail++; $display("[TB] FAIL rstp_map_post: got %h want %h", o_ant_posinfo, exp_map); end
      n_tests++; if (o_cfg_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rstp_done_post: got %b want 0", o_cfg_done); end
      n_tests++; if (o_frame_num !== exp_frame) begin n_fail++; $display("[TB] FAIL rstp_frame_post: got %0d want %0d", o_frame_num, exp_frame); end
   endtask

   initial begin
      test_reset();
      test_frame_headers();
      test_commit();
      test_reject();
      test_back_to_back();
      test_early();
      test_lost();
      test_hd_during_check();
      test_reset_in_pend();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
